// File: rtl/counter_mod_bcd.sv
// counter_mod_bcd: modulo-N up/down counter with BCD outputs, run/stop button, set mode and clamped load
module counter_mod_bcd #(
    parameter int MODULUS = 60,
    parameter int WIDTH   = 6,
    parameter int DIGITS  = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cnt_en,
    input  logic                  i_btn_run,
    input  logic                  i_btn_inc,
    input  logic                  i_set_mode,
    input  logic                  i_dir_up,
    input  logic                  i_load,
    input  logic [WIDTH-1:0]      i_load_val,
    output logic [WIDTH-1:0]      o_count,
    output logic [4*DIGITS-1:0]   o_bcd_out,
    output logic                  o_running,
    output logic                  o_tc,
    output logic                  o_carry_out
);
    localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MODULUS-1);

    logic [2:0]       r_rst_sync;
    logic [1:0]       r_run_sync;
    logic [1:0]       r_inc_sync;
    logic             r_run_prev;
    logic             r_inc_prev;
    logic [WIDTH-1:0] r_count;
    logic             r_running;
    logic             w_live;
    logic             w_run_evt;
    logic             w_inc_evt;
    logic             w_advance;
    logic             w_oor;
    logic [WIDTH-1:0] w_load_clamped;
    logic [WIDTH-1:0] w_inc;
    logic [WIDTH-1:0] w_dec;
    logic [WIDTH-1:0] w_count_nxt;
    int               w_bcd_tmp;

    // Reset release is stretched over three edges so the button pipelines settle on the real pin level first
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_rst_sync <= '0;
        else        r_rst_sync <= {r_rst_sync[1:0], 1'b1};
    end

    assign w_live = r_rst_sync[2];

    // Button synchronisers and previous-value flops run during the release window so a held button is absorbed
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_run_sync <= '1;
            r_inc_sync <= '1;
            r_run_prev <= 1'b1;
            r_inc_prev <= 1'b1;
        end else begin
            r_run_sync <= {r_run_sync[0], i_btn_run};
            r_inc_sync <= {r_inc_sync[0], i_btn_inc};
            r_run_prev <= r_run_sync[1];
            r_inc_prev <= r_inc_sync[1];
        end
    end

    assign w_run_evt      = w_live & r_run_prev & ~r_run_sync[1];
    assign w_inc_evt      = w_live & r_inc_prev & ~r_inc_sync[1];
    assign w_advance      = r_running & i_cnt_en & ~i_set_mode & ~i_load;
    assign w_oor          = {1'b0, r_count} >= MOD_W;
    assign w_load_clamped = ({1'b0, i_load_val} < MOD_W) ? i_load_val : MAX_C;
    assign w_inc          = (r_count == MAX_C) ? '0 : r_count + 1'b1;
    assign w_dec          = (r_count == '0) ? MAX_C : r_count - 1'b1;
    assign w_count_nxt    = i_load                    ? w_load_clamped :
                            w_oor                     ? '0 :
                            (i_set_mode & w_inc_evt)  ? w_inc :
                            w_advance                 ? (i_dir_up ? w_inc : w_dec) :
                                                        r_count;

    // Count and run/stop state; held cleared until the reset release window has passed
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_count   <= '0;
            r_running <= 1'b1;
        end else if (!w_live) begin
            r_count   <= '0;
            r_running <= 1'b1;
        end else begin
            r_count   <= w_count_nxt;
            r_running <= r_running ^ w_run_evt;
        end
    end

    // Binary to BCD by repeated division; digits beyond the value come out zero
    always_comb begin
        w_bcd_tmp = int'(r_count);
        o_bcd_out = '0;
        for (int d = 0; d < DIGITS; d++) begin
            o_bcd_out[4*d +: 4] = 4'(w_bcd_tmp % 10);
            w_bcd_tmp           = w_bcd_tmp / 10;
        end
    end

    assign o_count     = r_count;
    assign o_running   = r_running;
    assign o_tc        = i_dir_up ? (r_count == MAX_C) : (r_count == '0);
    assign o_carry_out = o_tc & w_advance;
endmodule

// File: tb/tb_counter_mod_bcd.sv
// tb_counter_mod_bcd: self-checking bench for counter_mod_bcd (MODULUS 60 and 24 instances)
module tb_counter_mod_bcd;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cnt_en = 1'b0;
    logic       btn_run = 1'b1;
    logic       btn_inc = 1'b1;
    logic       set_mode = 1'b0;
    logic       dir_up = 1'b1;
    logic       load = 1'b0;
    logic [5:0] load_val = 6'd0;
    logic [5:0] count60;
    logic [7:0] bcd60;
    logic       run60, tc60, carry60;
    logic [4:0] count24;
    logic [7:0] bcd24;
    logic       run24, tc24, carry24;
    logic       carry_in_set = 1'b0;
    int         checks = 0;
    int         errors = 0;

    typedef struct {string tag; int cnt;} sb_t;
    typedef struct {logic ce; logic dir; logic ld; logic [5:0] lv; logic sm; int carry; int cnt;} vec_t;
    sb_t  sb[$];
    vec_t vecs[11];

    always #5 clk = ~clk;

    counter_mod_bcd #(.MODULUS(60), .WIDTH(6), .DIGITS(2)) dut60 (
        .i_clk(clk), .i_rst(rst_n), .i_cnt_en(cnt_en), .i_btn_run(btn_run), .i_btn_inc(btn_inc),
        .i_set_mode(set_mode), .i_dir_up(dir_up), .i_load(load), .i_load_val(load_val),
        .o_count(count60), .o_bcd_out(bcd60), .o_running(run60), .o_tc(tc60), .o_carry_out(carry60)
    );

    counter_mod_bcd #(.MODULUS(24), .WIDTH(5), .DIGITS(2)) dut24 (
        .i_clk(clk), .i_rst(rst_n), .i_cnt_en(cnt_en), .i_btn_run(btn_run), .i_btn_inc(btn_inc),
        .i_set_mode(set_mode), .i_dir_up(dir_up), .i_load(load), .i_load_val(load_val[4:0]),
        .o_count(count24), .o_bcd_out(bcd24), .o_running(run24), .o_tc(tc24), .o_carry_out(carry24)
    );

    always @(negedge clk) if (set_mode && carry60) carry_in_set <= 1'b1;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    function automatic int to_bcd(input int v);
        return (v / 10) * 16 + v % 10;
    endfunction

    task automatic step(input logic ce, input int carry, input int cnt, input string tag);
        sb_t e;
        @(negedge clk);
        cnt_en = ce;
        #1;
        chk({tag, "_carry"}, int'(carry60), carry);
        sb.push_back('{tag, cnt});
        @(posedge clk);
        #1;
        cnt_en = 1'b0;
        e = sb.pop_front();
        chk(e.tag, int'(count60), e.cnt);
        chk({e.tag, "_bcd"}, int'(bcd60), to_bcd(e.cnt));
    endtask

    task automatic do_reset();
        @(negedge clk);
        cnt_en = 1'b0; load = 1'b0; set_mode = 1'b0; dir_up = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic press(input logic inc);
        @(negedge clk);
        if (inc) btn_inc = 1'b0; else btn_run = 1'b0;
        repeat (4) @(negedge clk);
        btn_inc = 1'b1;
        btn_run = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int exp_set[3];
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 6'd0,  1'b0, 0, 1};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 6'd0,  1'b0, 0, 0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 6'd0,  1'b0, 1, 59};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 6'd0,  1'b0, 1, 0};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 6'd45, 1'b0, 0, 45};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 6'd63, 1'b0, 0, 59};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 6'd60, 1'b0, 0, 59};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 6'd0,  1'b0, 1, 0};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 6'd0,  1'b0, 0, 0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 6'd0,  1'b1, 0, 0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 6'd0,  1'b0, 0, 1};
        exp_set  = '{59, 0, 1};

        repeat (2) @(negedge clk);
        #1;
        chk("rst_count", int'(count60), 0);
        chk("rst_running", int'(run60), 1);
        chk("rst_carry", int'(carry60), 0);
        chk("rst_bcd", int'(bcd60), 0);
        chk("rst_tc", int'(tc60), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt_en = 1'b1;
        @(posedge clk);
        #1;
        chk("release_hold", int'(count60), 0);
        @(negedge clk);
        cnt_en = 1'b0;
        repeat (4) @(negedge clk);

        for (int i = 0; i <= 60; i++)
            step(1'b1, (i == 59) ? 1 : 0, (i + 1) % 60, $sformatf("up%0d", i));

        do_reset();
        dir_up = 1'b0;
        @(negedge clk);
        cnt_en = 1'b1;
        #1;
        chk("m24_tc0", int'(tc24), 1);
        chk("m24_carry0", int'(carry24), 1);
        @(posedge clk);
        #1;
        cnt_en = 1'b0;
        chk("m24_wrap", int'(count24), 23);
        chk("m24_bcd", int'(bcd24), 'h23);
        @(negedge clk);
        cnt_en = 1'b1;
        #1;
        chk("m24_carry1", int'(carry24), 0);
        @(posedge clk);
        #1;
        cnt_en = 1'b0;
        chk("m24_dec", int'(count24), 22);

        do_reset();
        for (int i = 0; i < 11; i++) begin
            dir_up = vecs[i].dir; load = vecs[i].ld; load_val = vecs[i].lv; set_mode = vecs[i].sm;
            step(vecs[i].ce, vecs[i].carry, vecs[i].cnt, $sformatf("vec%0d", i));
        end
        load = 1'b0; set_mode = 1'b0; dir_up = 1'b1;

        @(negedge clk);
        btn_run = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("run_lat%0d", k), int'(run60), (k < 3) ? 1 : 0);
        end
        repeat (7) @(posedge clk);
        #1;
        chk("run_held", int'(run60), 0);
        @(negedge clk);
        btn_run = 1'b1;
        repeat (4) @(negedge clk);
        step(1'b1, 0, 1, "stopped");
        press(1'b0);
        chk("run_resume", int'(run60), 1);
        step(1'b1, 0, 2, "resumed");

        load = 1'b1; load_val = 6'd58;
        step(1'b0, 0, 58, "ld58");
        load = 1'b0;
        set_mode = 1'b1;
        cnt_en = 1'b1;
        for (int j = 0; j < 3; j++) begin
            press(1'b1);
            chk($sformatf("set_inc%0d", j), int'(count60), exp_set[j]);
        end
        cnt_en = 1'b0;
        chk("set_no_carry", int'(carry_in_set), 0);
        set_mode = 1'b0;

        press(1'b0);
        chk("stop_before_rst", int'(run60), 0);
        load = 1'b1; load_val = 6'd37;
        step(1'b0, 0, 37, "ld37");
        load = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_count", int'(count60), 0);
        chk("async_running", int'(run60), 1);
        chk("async_bcd", int'(bcd60), 0);
        btn_run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("held_no_evt", int'(run60), 1);
        btn_run = 1'b1;
        repeat (4) @(negedge clk);
        chk("held_release", int'(run60), 1);
        step(1'b1, 0, 1, "restart");
        press(1'b0);
        chk("toggle_after_rst", int'(run60), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
